// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between NUM_REQ requesters with timeout recovery
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_SIZE = 32,
  parameter int CMD_SIZE_LOG2 = 3,
  parameter int TIMEOUT = 64,
  localparam int CMD_W = 2 ** CMD_SIZE_LOG2,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(TIMEOUT)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*CMD_W-1:0]     req_cmd,
  input  logic [NUM_REQ*NUM_SIZE-1:0]  req_in1,
  input  logic [NUM_REQ*NUM_SIZE-1:0]  req_in2,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [IW-1:0]                rsp_id,
  output logic [NUM_SIZE-1:0]          rsp_data,
  output logic                         rsp_err,
  output logic                         alu_reset,
  output logic                         alu_enable,
  output logic [CMD_W-1:0]             alu_cmd,
  output logic [NUM_SIZE-1:0]          alu_in1,
  output logic [NUM_SIZE-1:0]          alu_in2,
  input  logic [NUM_SIZE-1:0]          alu_out,
  input  logic                         alu_valid
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [IW-1:0] ptr, g;
  logic [CW-1:0] cnt;
  logic abort_q, any;
  // winner is the valid requester at the smallest offset from ptr; only offered in IDLE
  always_comb begin
    g = '0;
    any = 1'b0;
    req_ready = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && (int'(ptr) + k) % NUM_REQ == i) begin
          g = IW'(i);
          any = 1'b1;
        end
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = any && g == IW'(i) && state == IDLE && !reset;
  end
  assign alu_reset = reset | abort_q;
  // accept, issue, wait for result or timeout, then hold the response until consumed
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      abort_q <= 1'b0;
      alu_enable <= 1'b0;
      alu_cmd <= '0;
      alu_in1 <= '0;
      alu_in2 <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      alu_enable <= 1'b0;
      abort_q <= 1'b0;
      case (state)
        IDLE: if (any) begin
          for (int i = 0; i < NUM_REQ; i++)
            if (g == IW'(i)) begin
              alu_cmd <= req_cmd[i*CMD_W +: CMD_W];
              alu_in1 <= req_in1[i*NUM_SIZE +: NUM_SIZE];
              alu_in2 <= req_in2[i*NUM_SIZE +: NUM_SIZE];
            end
          rsp_id <= g;
          ptr <= (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
          alu_enable <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (alu_valid) begin
          rsp_data <= alu_out;
          rsp_err <= 1'b0;
          rsp_valid <= 1'b1;
          state <= RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          rsp_data <= '0;
          rsp_err <= 1'b1;
          rsp_valid <= 1'b1;
          abort_q <= 1'b1;
          state <= RESP;
        end else
          cnt <= cnt + 1'b1;
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench with a round-robin reference model and a bench-side ALU
module tb_alu_arbiter;
  localparam int N = 4, W = 32, CW = 8, TO = 8;
  logic clk = 0, reset = 1, rsp_ready = 1, alu_valid = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*CW-1:0] req_cmd;
  logic [N*W-1:0] req_in1, req_in2;
  logic rsp_valid, rsp_err, alu_reset, alu_enable;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_data, alu_in1, alu_in2, alu_out = '0;
  logic [CW-1:0] alu_cmd;
  logic [CW-1:0] opc [N];
  logic [W-1:0] op1 [N], op2 [N];
  int checks = 0, failures = 0, mptr = 0;

  alu_arbiter #(.NUM_REQ(N), .NUM_SIZE(W), .CMD_SIZE_LOG2(3), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_in1(req_in1), .req_in2(req_in2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .alu_reset(alu_reset), .alu_enable(alu_enable), .alu_cmd(alu_cmd),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out), .alu_valid(alu_valid));

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < N; i++) begin
      req_cmd[i*CW +: CW] = opc[i];
      req_in1[i*W +: W] = op1[i];
      req_in2[i*W +: W] = op2[i];
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit rnd);
    for (int i = 0; i < N; i++) begin
      opc[i] = rnd ? CW'($urandom) : CW'(i + 1);
      op1[i] = rnd ? $urandom : W'(i * 100 + 1);
      op2[i] = rnd ? $urandom : W'(i);
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset = 1;
    tick();
    reset = 0;
    mptr = 0;
  endtask

  // reference arbitration: first valid requester searching mptr, mptr+1, ... modulo N
  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  // bench ALU: adds its operands and answers lat cycles after the enable pulse
  task automatic serve(input int lat);
    repeat (lat) tick();
    alu_out = alu_in1 + alu_in2;
    alu_valid = 1;
    tick();
    alu_valid = 0;
    alu_out = '0;
  endtask

  // offers mask m, records what the DUT did, leaves the bench in the first RESP cycle
  task automatic op(input logic [N-1:0] m, input int lat, output int e, output logic [N-1:0] rdy,
                    output logic en, output logic [CW+2*W-1:0] ins);
    e = pick(m);
    req_valid = m;
    #1;
    rdy = req_ready;
    tick();
    req_valid = '0;
    en = alu_enable;
    ins = {alu_cmd, alu_in1, alu_in2};
    mptr = (e + 1) % N;
    serve(lat);
  endtask

  task automatic test_reset();
    reset = 1;
    req_valid = '1;
    rsp_ready = 0;
    tick();
    tick();
    checks++;
    if ({req_ready, rsp_valid, rsp_err, alu_enable, alu_cmd, alu_in1, alu_in2, rsp_data, rsp_id} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {req_ready, rsp_valid, rsp_err, alu_enable, alu_cmd, alu_in1, alu_in2, rsp_data, rsp_id});
    end
    checks++;
    if (alu_reset !== 1'b1) begin failures++; $display("FAIL reset_alu_reset got=%b exp=1", alu_reset); end
    req_valid = '0;
    reset = 0;
    rsp_ready = 1;
    mptr = 0;
    tick();
    checks++;
    if (alu_reset !== 1'b0) begin failures++; $display("FAIL reset_release_alu_reset got=%b exp=0", alu_reset); end
  endtask

  task automatic test_single();
    int e; logic [N-1:0] rdy; logic en; logic [CW+2*W-1:0] ins;
    opc[0] = 8'h01; op1[0] = 5; op2[0] = 7;
    op(4'b0001, 3, e, rdy, en, ins);
    checks++;
    if ({rdy, en, ins} !== {4'b0001, 1'b1, 8'h01, 32'd5, 32'd7}) begin
      failures++; $display("FAIL single_issue got=%h exp=%h", {rdy, en, ins}, {4'b0001, 1'b1, 8'h01, 32'd5, 32'd7});
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err, alu_enable} !== {1'b1, 2'd0, 32'd12, 1'b0, 1'b0}) begin
      failures++; $display("FAIL single_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_data, rsp_err, alu_enable},
                           {1'b1, 2'd0, 32'd12, 1'b0, 1'b0});
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_clear got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_fairness();
    int e; logic [N-1:0] rdy; logic en; logic [CW+2*W-1:0] ins;
    do_reset();
    load(0);
    rsp_ready = 1;
    for (int r = 0; r < 6; r++) begin
      op('1, 1 + r % 3, e, rdy, en, ins);
      checks++;
      if (rdy !== N'(1 << (r % N)) || rsp_id !== 2'(r % N)) begin
        failures++; $display("FAIL fair_grant%0d got=%b/%0d exp=%b/%0d", r, rdy, rsp_id, N'(1 << (r % N)), r % N);
      end
      checks++;
      if (rsp_data !== W'((r % N) * 100 + 1 + (r % N)) || ins[2*W-1:W] !== W'((r % N) * 100 + 1)) begin
        failures++; $display("FAIL fair_data%0d got=%h exp=%h", r, rsp_data, (r % N) * 100 + 1 + (r % N));
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    int e; logic [N-1:0] rdy; logic en; logic [CW+2*W-1:0] ins;
    logic [N-1:0] wm [4] = '{4'b0100, 4'b1010, 4'b1010, 4'b1111};
    int we [4] = '{2, 3, 1, 2};
    for (int j = 0; j < 4; j++) begin
      op(wm[j], 2, e, rdy, en, ins);
      checks++;
      if (rdy !== N'(1 << we[j]) || rsp_id !== 2'(we[j])) begin
        failures++; $display("FAIL wrap%0d got=%b/%0d exp=%b/%0d", j, rdy, rsp_id, N'(1 << we[j]), we[j]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int e; logic [N-1:0] rdy; logic en; logic [CW+2*W-1:0] ins;
    int bad = 0;
    op1[1] = 32'hDE00; op2[1] = 32'h00AD;
    rsp_ready = 0;
    op(4'b0010, 2, e, rdy, en, ins);
    req_valid = '1;
    #1;
    for (int c = 0; c < 10; c++) begin
      if ({rsp_valid, rsp_id, rsp_data, rsp_err, req_ready} !== {1'b1, 2'd1, 32'hDEAD, 1'b0, 4'b0000}) begin
        bad++;
        $display("FAIL bp_hold%0d got=%h exp=%h", c, {rsp_valid, rsp_id, rsp_data, rsp_err, req_ready},
                 {1'b1, 2'd1, 32'hDEAD, 1'b0, 4'b0000});
      end
      tick();
    end
    checks++;
    if (bad != 0) failures++;
    rsp_ready = 1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin
      failures++; $display("FAIL bp_release got=%b/%b exp=0/0100", rsp_valid, req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    int e, cnt; logic [N-1:0] rdy; logic en; logic [CW+2*W-1:0] ins;
    load(1);
    rsp_ready = 0;
    e = pick(4'b0001);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    mptr = (e + 1) % N;
    cnt = 0;
    while (!rsp_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt != TO + 1) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", cnt, TO + 1); end
    checks++;
    if ({rsp_err, rsp_data, alu_reset, rsp_id} !== {1'b1, 32'd0, 1'b1, 2'(e)}) begin
      failures++; $display("FAIL to_rsp got=%h exp=%h", {rsp_err, rsp_data, alu_reset, rsp_id}, {1'b1, 32'd0, 1'b1, 2'(e)});
    end
    tick();
    checks++;
    if (alu_reset !== 1'b0 || rsp_valid !== 1'b1) begin
      failures++; $display("FAIL to_pulse got=%b/%b exp=0/1", alu_reset, rsp_valid);
    end
    rsp_ready = 1;
    tick();
    op(4'b1111, 3, e, rdy, en, ins);
    checks++;
    if ({rdy, rsp_id, rsp_err, rsp_data} !== {N'(1 << e), 2'(e), 1'b0, op1[e] + op2[e]}) begin
      failures++; $display("FAIL to_recover got=%h exp=%h", {rdy, rsp_id, rsp_err, rsp_data},
                           {N'(1 << e), 2'(e), 1'b0, op1[e] + op2[e]});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int e, seen = 0; logic [N-1:0] rdy; logic en; logic [CW+2*W-1:0] ins;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    tick();
    reset = 1;
    alu_valid = 1;
    alu_out = $urandom;
    tick();
    checks++;
    if ({rsp_valid, alu_enable, alu_cmd, alu_in1, alu_in2, rsp_data, rsp_err, rsp_id, alu_reset} !==
        {1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b1}) begin
      failures++; $display("FAIL midreset_outputs got=%h", {rsp_valid, alu_enable, alu_cmd, alu_in1, alu_in2,
                           rsp_data, rsp_err, rsp_id, alu_reset});
    end
    reset = 0;
    alu_valid = 0;
    mptr = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midreset_no_rsp got=%0d exp=0", seen); end
    load(0);
    op(4'b1111, 2, e, rdy, en, ins);
    checks++;
    if (rdy !== 4'b0001 || rsp_id !== 2'd0) begin
      failures++; $display("FAIL midreset_first_grant got=%b/%0d exp=0001/0", rdy, rsp_id);
    end
    tick();
  endtask

  task automatic test_random();
    int e, w; logic [N-1:0] m, rdy; logic en; logic [CW+2*W-1:0] ins;
    for (int r = 0; r < 25; r++) begin
      load(1);
      m = N'($urandom_range(1, 15));
      op(m, $urandom_range(1, 6), e, rdy, en, ins);
      checks++;
      if ({rdy, en, ins} !== {N'(1 << e), 1'b1, opc[e], op1[e], op2[e]}) begin
        failures++; $display("FAIL rnd_issue%0d got=%h exp=%h", r, {rdy, en, ins}, {N'(1 << e), 1'b1, opc[e], op1[e], op2[e]});
      end
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'(e), op1[e] + op2[e], 1'b0}) begin
        failures++; $display("FAIL rnd_rsp%0d got=%h exp=%h", r, {rsp_valid, rsp_id, rsp_data, rsp_err},
                             {1'b1, 2'(e), op1[e] + op2[e], 1'b0});
      end
      w = $urandom_range(0, 2);
      rsp_ready = 0;
      repeat (w) tick();
      rsp_ready = 1;
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rnd_done%0d got=%b exp=0", r, rsp_valid); end
    end
  endtask

  initial begin
    load(0);
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one pandas-op ALU (enable/cmd/in1/in2 in; out/valid back) between NUM_REQ independent requesters.
- Accepts one operation at a time with round-robin fairness and issues it to the ALU as a single-cycle enable pulse.
- Waits for the ALU result and returns it to the winning requester, tagged with the requester id.
- Sits between host-side column streamers and the ALU; also owns ALU reset and timeout recovery.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- NUM_SIZE, 32: operand/result width.
- CMD_SIZE_LOG2, 3: command width is CMD_W = 2**CMD_SIZE_LOG2 bits.
- TIMEOUT, 64: max cycles in WAIT before abort (>=2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set
- req_cmd  in  NUM_REQ*CMD_W  packed commands; requester i at [i*CMD_W +: CMD_W]
- req_in1  in  NUM_REQ*NUM_SIZE  packed operand 1
- req_in2  in  NUM_REQ*NUM_SIZE  packed operand 2
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_id  out  $clog2(NUM_REQ)  requester index of response
- rsp_data  out  NUM_SIZE  ALU result
- rsp_err  out  1  response is a timeout abort (rsp_data = 0)
- alu_reset  out  1  ALU reset
- alu_enable  out  1  ALU enable, one-cycle pulse per op
- alu_cmd  out  CMD_W  registered command
- alu_in1  out  NUM_SIZE  registered operand 1
- alu_in2  out  NUM_SIZE  registered operand 2
- alu_out  in  NUM_SIZE  ALU result
- alu_valid  in  1  ALU result valid

Behaviour:
- Reset (clk edge with reset=1): state=IDLE; rr pointer=0; all outputs 0 except alu_reset=1. alu_reset = reset OR abort pulse.
- Reset mid-operation: in-flight op dropped, no response produced, pointer returns to 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner g = first i with req_valid[i], searching ptr, ptr+1, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally; all other req_ready bits 0. req_ready is 0 outside IDLE.
  - On transfer: latch req_cmd/in1/in2 slice g into the alu_* registers, set id=g, ptr=(g+1) mod NUM_REQ, go to ISSUE.
  - No req_valid set: remain in IDLE, ptr unchanged.
- ISSUE: alu_enable=1 for exactly this cycle; alu_cmd/in1/in2 stable from ISSUE until return to IDLE; go to WAIT. alu_valid in ISSUE is ignored.
- WAIT:
  - Counter starts at 0 on entry and increments each cycle.
  - alu_valid=1: capture alu_out into rsp_data, rsp_err=0, go to RESP.
  - Else if counter reaches TIMEOUT-1: rsp_data=0, rsp_err=1, alu_reset=1 for the next cycle (abort pulse), go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data/rsp_err held stable until rsp_ready=1.
  - On rsp_valid&rsp_ready: go to IDLE, rsp_valid=0 next cycle.
  - alu_valid in RESP is ignored.
- Latency: req accept at cycle T -> alu_enable at T+1 -> alu_valid at cycle V -> rsp_valid at V+1. Best-case turnaround with rsp_ready held high: next accept possible at V+2.
- Only one op is in flight at a time; no ALU pipelining.
- Requesters may drop req_valid before acceptance without error.
- Simultaneous requests are resolved by the rr pointer only. Starvation-free: every valid requester is granted within NUM_REQ accepts.

Test Plan:
- Single op: reset, then req0 cmd=8'h01, in1=5, in2=7; bench ALU model returns 12 after 3 cycles -> alu_enable pulse at T+1, rsp_valid with id=0, data=12, err=0 at V+1.
- Fairness: all 4 req_valid held high with distinct operands and rsp_ready=1 -> grant order 0,1,2,3,0,1; exactly one req_ready bit per IDLE cycle.
- Pointer wrap: ptr=3 after granting req2; only req1 and req3 valid -> req3 granted first, then req1, then ptr=2.
- Backpressure: rsp_ready=0 for 10 cycles after result 0xDEAD -> rsp_valid/rsp_data/rsp_id stable, req_ready stays 0; rsp_ready=1 -> IDLE next cycle.
- Timeout: ALU model never asserts alu_valid, TIMEOUT=8 -> rsp_err=1, rsp_data=0, alu_reset high one cycle, arbiter accepts the next request normally.
- Reset mid-op: reset asserted in WAIT -> no rsp_valid, all outputs 0, alu_reset=1, ptr=0; first request after reset is granted by order starting from req0.
